// File: rtl/ser_pkg.sv
// Shared definitions for the serial link: FSM state type, minimum legal
// modifier and the modifier-to-bit-length mapping used by both link ends.
package ser_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

  localparam int SER_MOD_MIN = 3;

  // Bit length for a modifier: 0 selects the full word, 1..2 and anything
  // that does not fit the word are illegal and map to 0.
  function automatic int ser_len(input int mod, input int data_w = 16);
    if (mod == 0) return data_w;
    if (mod < SER_MOD_MIN || mod >= data_w) return 0;
    return mod;
  endfunction

endpackage

// File: rtl/serializer.sv
// Parallel-to-serial transmitter: latches a word plus bit-count modifier and
// shifts the leading L bits out MSB-first with a per-bit valid strobe.
module serializer
  import ser_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int MOD_W  = $clog2(DATA_W)
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [MOD_W-1:0]  data_mod_i,
  input  logic              data_val_i,
  output logic              ser_data_o,
  output logic              ser_data_val_o,
  output logic              busy_o
);

  // One extra bit so a full-width length loads without wrapping to zero.
  localparam int CNT_W = MOD_W + 1;

  ser_state_t        state_q;
  logic [DATA_W-1:0] shift_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ser_data_q;
  logic              ser_val_q;
  logic              busy_q;

  logic [CNT_W-1:0]  load_len;
  logic              accept;

  always_comb begin
    load_len = CNT_W'(ser_len(int'(data_mod_i), DATA_W));
    accept   = (state_q == IDLE) && data_val_i && (load_len != '0);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would chain the shift within one cycle.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      ser_data_q <= 1'b0;
      ser_val_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          ser_data_q <= 1'b0;
          ser_val_q  <= 1'b0;
          busy_q     <= 1'b0;
          if (accept) begin
            // The MSB goes straight to the output flop so it is valid next cycle.
            state_q    <= SEND;
            ser_data_q <= data_i[DATA_W-1];
            ser_val_q  <= 1'b1;
            busy_q     <= 1'b1;
            shift_q    <= {data_i[DATA_W-2:0], 1'b0};
            cnt_q      <= load_len;
          end
        end
        SEND: begin
          // cnt_q counts bits still on the wire, including the one shown now.
          if (cnt_q == CNT_W'(1)) begin
            state_q    <= IDLE;
            ser_data_q <= 1'b0;
            ser_val_q  <= 1'b0;
            busy_q     <= 1'b0;
            cnt_q      <= '0;
            shift_q    <= '0;
          end else begin
            ser_data_q <= shift_q[DATA_W-1];
            ser_val_q  <= 1'b1;
            busy_q     <= 1'b1;
            shift_q    <= {shift_q[DATA_W-2:0], 1'b0};
            cnt_q      <= cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ser_data_o     = ser_data_q;
  assign ser_data_val_o = ser_val_q;
  assign busy_o         = busy_q;

endmodule
